// File: rtl/ddr_req_arbiter.sv
// Write/read command arbiter in front of the DDR memory interface, with read-starvation guard
// and outstanding-read limit. Define ARB_GRANT_STATS_EN to enable per-type grant counters.
module ddr_req_arbiter #(
  parameter int ADX_W        = 27,
  parameter int DATA_W       = 128,
  parameter int MAX_RD_OUT   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_req,
  input  logic [ADX_W-1:0]  wr_adx,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADX_W-1:0]  rd_adx,
  output logic              rd_ack,
  output logic              mem_cmd_valid,
  output logic              mem_cmd_rnw,
  output logic [ADX_W-1:0]  mem_cmd_adx,
  output logic [DATA_W-1:0] mem_cmd_data,
  input  logic              mem_cmd_ready,
  input  logic              rd_return_pop,
  output logic [3:0]        rd_outstanding,
  output logic              idle,
  output logic [15:0]       wr_grants,
  output logic [15:0]       rd_grants
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e              state_q, state_d;
  logic                rnw_q, rnw_d;
  logic [ADX_W-1:0]    adx_q, adx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_ack_q, wr_ack_d;
  logic                rd_ack_q, rd_ack_d;
  logic [7:0]          starve_q, starve_d;
  logic [3:0]          rd_out_q, rd_out_d;
  logic                rd_elig, starved, wr_win, rd_win, accept, rd_inc, rd_dec;

  always_comb begin
    rd_elig  = rd_req && (rd_out_q < 4'(MAX_RD_OUT));
    starved  = (starve_q == 8'(STARVE_LIMIT));
    wr_win   = wr_req && !(rd_elig && starved);
    rd_win   = rd_elig && !wr_win;
    accept   = (state_q == ISSUE) && mem_cmd_ready;
    rd_inc   = accept && rnw_q;
    rd_dec   = rd_return_pop && (rd_out_q != 4'd0);

    state_d  = state_q;
    rnw_d    = rnw_q;
    adx_d    = adx_q;
    data_d   = data_q;
    wr_ack_d = 1'b0;
    rd_ack_d = 1'b0;
    starve_d = starve_q;

    case (state_q)
      IDLE: begin
        if (wr_win) begin
          state_d  = ISSUE;
          rnw_d    = 1'b0;
          adx_d    = wr_adx;
          data_d   = wr_data;
          wr_ack_d = 1'b1;
          if (rd_elig && !starved) starve_d = starve_q + 8'd1;
        end else if (rd_win) begin
          // data register keeps the last write payload for reads
          state_d  = ISSUE;
          rnw_d    = 1'b1;
          adx_d    = rd_adx;
          rd_ack_d = 1'b1;
          starve_d = 8'd0;
        end
      end
      ISSUE: if (mem_cmd_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!rd_req) starve_d = 8'd0;

    case ({rd_inc, rd_dec})
      2'b10:   rd_out_d = rd_out_q + 4'd1;
      2'b01:   rd_out_d = rd_out_q - 4'd1;
      default: rd_out_d = rd_out_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rnw_q    <= 1'b0;
      adx_q    <= '0;
      data_q   <= '0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      starve_q <= 8'd0;
      rd_out_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      rnw_q    <= rnw_d;
      adx_q    <= adx_d;
      data_q   <= data_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
      starve_q <= starve_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign mem_cmd_valid  = (state_q == ISSUE);
  assign mem_cmd_rnw    = rnw_q;
  assign mem_cmd_adx    = adx_q;
  assign mem_cmd_data   = data_q;
  assign wr_ack         = wr_ack_q;
  assign rd_ack         = rd_ack_q;
  assign rd_outstanding = rd_out_q;
  assign idle           = (state_q == IDLE) && !wr_req && !rd_req && (rd_out_q == 4'd0);

`ifdef ARB_GRANT_STATS_EN
  logic [15:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_cnt_q <= 16'd0;
      rd_cnt_q <= 16'd0;
    end else if (accept) begin
      if (rnw_q) rd_cnt_q <= rd_cnt_q + 16'd1;
      else       wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign wr_grants = wr_cnt_q;
  assign rd_grants = rd_cnt_q;
`else
  assign wr_grants = 16'd0;
  assign rd_grants = 16'd0;
`endif

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed self-checking bench for ddr_req_arbiter (MAX_RD_OUT=2, STARVE_LIMIT=4).
module tb_ddr_req_arbiter;
  localparam int ADX_W  = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              wr_req = 1'b0, rd_req = 1'b0;
  logic [ADX_W-1:0]  wr_adx = '0, rd_adx = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ack, rd_ack;
  logic              mem_cmd_valid, mem_cmd_rnw;
  logic [ADX_W-1:0]  mem_cmd_adx;
  logic [DATA_W-1:0] mem_cmd_data;
  logic              mem_cmd_ready = 1'b1;
  logic              rd_return_pop = 1'b0;
  logic [3:0]        rd_outstanding;
  logic              idle;
  logic [15:0]       wr_grants, rd_grants;

  int n_chk = 0;
  int n_fail = 0;

  ddr_req_arbiter #(.ADX_W(ADX_W), .DATA_W(DATA_W), .MAX_RD_OUT(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .wr_req(wr_req), .wr_adx(wr_adx), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_adx(rd_adx), .rd_ack(rd_ack),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_rnw(mem_cmd_rnw),
    .mem_cmd_adx(mem_cmd_adx), .mem_cmd_data(mem_cmd_data),
    .mem_cmd_ready(mem_cmd_ready), .rd_return_pop(rd_return_pop),
    .rd_outstanding(rd_outstanding), .idle(idle),
    .wr_grants(wr_grants), .rd_grants(rd_grants)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic do_reset();
    resetn = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_return_pop = 1'b0; mem_cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ack(input bit rd, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd ? rd_ack : wr_ack) begin ok = 1'b1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_cmd(input bit rd, input logic [ADX_W-1:0] a, input logic [DATA_W-1:0] d);
    if (rd) begin rd_req = 1'b1; rd_adx = a; end
    else begin wr_req = 1'b1; wr_adx = a; wr_data = d; end
    wait_ack(rd, "cmd_ack_timeout");
    wr_req = 1'b0; rd_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n, acks;
    logic [9:0] seq;
    logic [31:0] exp_w, exp_r;

    // reset state
    #3;
    chk("rst_valid", 32'(mem_cmd_valid), 32'd0);
    chk("rst_acks", {30'd0, wr_ack, rd_ack}, 32'd0);
    chk("rst_adx", 32'(mem_cmd_adx), 32'd0);
    chk("rst_out", 32'(rd_outstanding), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    do_reset();

    // single write, ready high
    wr_req = 1'b1; wr_adx = 12'h010; wr_data = 32'hABCD_0001;
    @(negedge clk);
    chk("w1_ack", 32'(wr_ack), 32'd1);
    chk("w1_valid", 32'(mem_cmd_valid), 32'd1);
    chk("w1_rnw", 32'(mem_cmd_rnw), 32'd0);
    chk("w1_adx", 32'(mem_cmd_adx), 32'h10);
    chk("w1_data", mem_cmd_data, 32'hABCD_0001);
    wr_req = 1'b0;
    @(negedge clk);
    chk("w1_idle", 32'(idle), 32'd1);
    chk("w1_valid_off", 32'(mem_cmd_valid), 32'd0);

    // both requesting continuously: starvation guard ordering
    do_reset();
    wr_req = 1'b1; rd_req = 1'b1; wr_adx = 12'h100; rd_adx = 12'h200;
    n = 0; seq = '0;
    for (int i = 0; i < 24 && n < 10; i++) begin
      @(negedge clk);
      if (wr_ack) n++;
      else if (rd_ack) begin seq[n] = 1'b1; n++; end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("starve_n", 32'(n), 32'd10);
    chk("starve_order", 32'(seq), 32'h210);
    @(negedge clk);
    chk("starve_out", 32'(rd_outstanding), 32'd2);

    // outstanding-read limit
    do_reset();
    rd_req = 1'b1; rd_adx = 12'h020; acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rd_ack) acks++;
    end
    chk("lim_acks", 32'(acks), 32'd2);
    chk("lim_out", 32'(rd_outstanding), 32'd2);
    chk("lim_blocked", 32'(mem_cmd_valid), 32'd0);
    wr_req = 1'b1; wr_adx = 12'h021;
    @(negedge clk);
    chk("lim_wr_ok", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
    @(negedge clk);
    rd_return_pop = 1'b1;
    @(negedge clk);
    rd_return_pop = 1'b0;
    chk("lim_pop", 32'(rd_outstanding), 32'd1);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rd_ack) acks++;
    end
    rd_req = 1'b0;
    chk("lim_acks2", 32'(acks), 32'd1);
    chk("lim_out2", 32'(rd_outstanding), 32'd2);
    chk("lim_not_idle", 32'(idle), 32'd0);

    // stalled write holds command stable with a single ack
    do_reset();
    mem_cmd_ready = 1'b0;
    wr_req = 1'b1; wr_adx = 12'h033; wr_data = 32'h1234_5678; acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(mem_cmd_valid), 32'd1);
      chk("stall_adx", 32'(mem_cmd_adx), 32'h33);
      chk("stall_data", mem_cmd_data, 32'h1234_5678);
      if (wr_ack) begin acks++; wr_req = 1'b0; end
    end
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    chk("stall_done", 32'(mem_cmd_valid), 32'd0);
    chk("stall_acks", 32'(acks), 32'd1);

    // accept and pop in the same cycle; pop at zero
    do_reset();
    do_cmd(1'b1, 12'h040, '0);
    chk("ap_out1", 32'(rd_outstanding), 32'd1);
    rd_req = 1'b1; rd_adx = 12'h041;
    wait_ack(1'b1, "ap_ack_timeout");
    chk("ap_rd_data_kept", mem_cmd_data, 32'd0);
    rd_req = 1'b0; rd_return_pop = 1'b1;
    @(negedge clk);
    rd_return_pop = 1'b0;
    chk("ap_same", 32'(rd_outstanding), 32'd1);
    rd_return_pop = 1'b1;
    @(negedge clk);
    chk("ap_pop", 32'(rd_outstanding), 32'd0);
    @(negedge clk);
    rd_return_pop = 1'b0;
    chk("ap_pop0", 32'(rd_outstanding), 32'd0);

    // grant stats and reset mid-issue
    do_reset();
    do_cmd(1'b0, 12'h050, 32'h5);
    do_cmd(1'b1, 12'h051, '0);
    do_cmd(1'b0, 12'h052, 32'h6);
    do_cmd(1'b1, 12'h053, '0);
    do_cmd(1'b0, 12'h054, 32'h7);
`ifdef ARB_GRANT_STATS_EN
    exp_w = 32'd3; exp_r = 32'd2;
`else
    exp_w = 32'd0; exp_r = 32'd0;
`endif
    chk("stat_wr", 32'(wr_grants), exp_w);
    chk("stat_rd", 32'(rd_grants), exp_r);
    mem_cmd_ready = 1'b0;
    wr_req = 1'b1; wr_adx = 12'h055; wr_data = 32'h99;
    @(negedge clk);
    chk("mid_valid", 32'(mem_cmd_valid), 32'd1);
    wr_req = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(mem_cmd_valid), 32'd0);
    chk("mid_rst_out", 32'(rd_outstanding), 32'd0);
    chk("mid_rst_grants", {wr_grants, rd_grants}, 32'd0);
    chk("mid_rst_cmd", {19'd0, mem_cmd_rnw, mem_cmd_adx}, 32'd0);
    chk("mid_rst_data", mem_cmd_data, 32'd0);
    chk("mid_rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    resetn = 1'b1; mem_cmd_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_quiet", {30'd0, mem_cmd_valid, wr_ack}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
